// File: rtl/micro_defs.sv
// Shared definitions for the 12-bit-instruction micro: widths, opcodes and
// the datapath select codes driven by the controller.
package micro_defs;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 12;

    typedef enum logic [3:0] {
        OpNop   = 4'h0,
        OpAdd   = 4'h1,
        OpSub   = 4'h2,
        OpNor   = 4'h3,
        OpMovrs = 4'h4,
        OpMovrd = 4'h5,
        OpJzr   = 4'h6,
        OpJzi   = 4'h7,
        OpJcr   = 4'h8,
        OpJci   = 4'h9,
        OpShl   = 4'hA,
        OpShr   = 4'hB,
        OpLdi   = 4'hC,
        OpHalt  = 4'hD
    } opcode_e;

    typedef enum logic [1:0] {
        AccAlu  = 2'b00,
        AccReg  = 2'b01,
        AccImm  = 2'b10,
        AccHold = 2'b11
    } selAcc_e;

    typedef enum logic [1:0] {
        AluPass = 2'b00,
        AluNor  = 2'b01,
        AluAdd  = 2'b10,
        AluSub  = 2'b11
    } aluOp_e;

    typedef enum logic [1:0] {
        ShNone  = 2'b00,
        ShLeft  = 2'b01,
        ShRsvd  = 2'b10,
        ShRight = 2'b11
    } shift_e;

endpackage

// File: rtl/alu_shift.sv
// Combinational ALU followed by a one-bit shifter; a shift's carry-out
// replaces the carry produced by the arithmetic op.
module alu_shift #(
    parameter int unsigned DW = micro_defs::DW
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    selAlu,
    output logic [DW-1:0] result,
    output logic          carry
);
    import micro_defs::*;

    logic [DW-1:0] opRes;
    logic          opCarry;
    logic [DW:0]   sum;

    always_comb begin
        opRes   = a;
        opCarry = 1'b0;
        sum     = '0;
        unique case (aluOp_e'(selAlu[3:2]))
            AluPass: opRes = a;
            AluNor:  opRes = ~(a | b);
            AluAdd: begin
                sum     = {1'b0, a} + {1'b0, b};
                opRes   = sum[DW-1:0];
                opCarry = sum[DW];
            end
            AluSub: begin
                // Carry-out of A + ~B + 1: set means no borrow.
                sum     = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
                opRes   = sum[DW-1:0];
                opCarry = sum[DW];
            end
            default: opRes = a;
        endcase
    end

    always_comb begin
        result = opRes;
        carry  = opCarry;
        unique case (shift_e'(selAlu[1:0]))
            ShLeft: begin
                result = {opRes[DW-2:0], 1'b0};
                carry  = opRes[DW-1];
            end
            ShRight: begin
                result = {1'b0, opRes[DW-1:1]};
                carry  = opRes[0];
            end
            default: begin
                result = opRes;
                carry  = opCarry;
            end
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Accumulator datapath: PC, IR, accumulator, 4-entry register file and Z/C
// flags, updated by controller strobes with no added latency.
module datapath #(
    parameter int unsigned DW   = micro_defs::DW,
    parameter int unsigned IW   = micro_defs::IW,
    parameter int unsigned NREG = 4
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          LoadIR,
    input  logic          IncPC,
    input  logic          SelPC,
    input  logic          LoadPC,
    input  logic          LoadReg,
    input  logic          LoadAcc,
    input  logic [1:0]    SelAcc,
    input  logic [3:0]    SelALU,
    input  logic [IW-1:0] instr_in,
    output logic [DW-1:0] pc_out,
    output logic [3:0]    Opcode,
    output logic          Z,
    output logic          C,
    output logic [DW-1:0] acc_out
);
    import micro_defs::*;

    logic [DW-1:0] pcQ, pcD;
    logic [IW-1:0] irQ, irD;
    logic [DW-1:0] accQ, accD;
    logic [DW-1:0] rfQ [NREG];
    logic [DW-1:0] rfD [NREG];
    logic          zQ, zD, cQ, cD;

    logic [1:0]    rs;
    logic [DW-1:0] imm;
    logic [DW-1:0] rfRead;
    logic [DW-1:0] aluRes;
    logic          aluCarry;

    // Operand fields always come from the registered IR.
    assign rs     = irQ[1:0];
    assign imm    = irQ[DW-1:0];
    assign rfRead = rfQ[rs];

    alu_shift #(
        .DW(DW)
    ) uAluShift (
        .a      (accQ),
        .b      (rfRead),
        .selAlu (SelALU),
        .result (aluRes),
        .carry  (aluCarry)
    );

    always_comb begin
        pcD  = pcQ;
        irD  = irQ;
        accD = accQ;
        zD   = zQ;
        cD   = cQ;
        rfD  = rfQ;

        if (LoadPC) begin
            pcD = SelPC ? rfRead : imm;
        end else if (IncPC) begin
            pcD = pcQ + DW'(1);
        end

        if (LoadIR) begin
            irD = instr_in;
        end

        if (LoadAcc) begin
            unique case (selAcc_e'(SelAcc))
                AccAlu: begin
                    accD = aluRes;
                    zD   = (aluRes == '0);
                    cD   = aluCarry;
                end
                AccReg:  accD = rfRead;
                AccImm:  accD = imm;
                default: accD = accQ;
            endcase
        end

        if (LoadReg) begin
            rfD[rs] = accQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!CLB) begin
            pcQ  <= '0;
            irQ  <= '0;
            accQ <= '0;
            zQ   <= 1'b0;
            cQ   <= 1'b0;
            rfQ  <= '{default: '0};
        end else begin
            pcQ  <= pcD;
            irQ  <= irD;
            accQ <= accD;
            zQ   <= zD;
            cQ   <= cD;
            rfQ  <= rfD;
        end
    end

    assign pc_out  = pcQ;
    assign Opcode  = irQ[IW-1:IW-4];
    assign Z       = zQ;
    assign C       = cQ;
    assign acc_out = accQ;

endmodule
